// File: rtl/memory_port_sequencer.sv
// Valid/ready request sequencer driving a single-port synchronous RAM (registered-address read).
// Optional write acknowledge response: define MEMORY_PORT_SEQUENCER_WRITE_ACK_EN.
module memory_port_sequencer #(
    parameter int unsigned DATAWIDTH    = 8,
    parameter int unsigned DATADEPTH    = 1024,
    parameter int unsigned ADDRESSWIDTH = $clog2(DATADEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [ADDRESSWIDTH-1:0] req_address_i,
    input  logic [DATAWIDTH-1:0]    req_data_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic                    rsp_write_o,
    output logic [DATAWIDTH-1:0]    rsp_data_o,
    output logic                    mem_write_en_o,
    output logic [DATAWIDTH-1:0]    mem_data_in_o,
    output logic [ADDRESSWIDTH-1:0] mem_address_o,
    input  logic [DATAWIDTH-1:0]    mem_data_out_i
);

    typedef enum logic [1:0] {StIdle, StRead, StResp} state_e;

    state_e                  state_q, state_d;
    logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
    logic [DATAWIDTH-1:0]    wdata_q, wdata_d;
    logic [DATAWIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic                    accept, pop;
`ifdef MEMORY_PORT_SEQUENCER_WRITE_ACK_EN
    logic                    rsp_write_q, rsp_write_d;
`endif

    // req_ready never looks at req_valid; only RESP forwards rsp_ready.
    always_comb begin
        req_ready_o = 1'b0;
        unique case (state_q)
            StIdle:  req_ready_o = 1'b1;
            StResp:  req_ready_o = rsp_ready_i;
            default: req_ready_o = 1'b0;
        endcase
        if (reset) begin
            req_ready_o = 1'b0;
        end
    end

    assign rsp_valid_o    = (state_q == StResp) && !reset;
    assign accept         = req_valid_i && req_ready_o;
    assign pop            = rsp_valid_o && rsp_ready_i;
    assign rsp_data_o     = rsp_data_q;
    assign mem_write_en_o = accept && req_write_i;
    assign mem_address_o  = accept ? req_address_i : addr_q;
    assign mem_data_in_o  = mem_write_en_o ? req_data_i : wdata_q;
    assign addr_d         = mem_address_o;
    assign wdata_d        = mem_data_in_o;

`ifdef MEMORY_PORT_SEQUENCER_WRITE_ACK_EN
    assign rsp_write_o = rsp_write_q;
`else
    assign rsp_write_o = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
`ifdef MEMORY_PORT_SEQUENCER_WRITE_ACK_EN
        rsp_write_d = rsp_write_q;
`endif
        unique case (state_q)
            StIdle, StResp: begin
                if (pop) begin
                    state_d = StIdle;
                end
                if (accept) begin
                    if (req_write_i) begin
`ifdef MEMORY_PORT_SEQUENCER_WRITE_ACK_EN
                        state_d     = StResp;
                        rsp_data_d  = req_data_i;
                        rsp_write_d = 1'b1;
`else
                        state_d = StIdle;
`endif
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                // RAM output is valid for the address registered at the accept edge.
                state_d    = StResp;
                rsp_data_d = mem_data_out_i;
`ifdef MEMORY_PORT_SEQUENCER_WRITE_ACK_EN
                rsp_write_d = 1'b0;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
`ifdef MEMORY_PORT_SEQUENCER_WRITE_ACK_EN
            rsp_write_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
`ifdef MEMORY_PORT_SEQUENCER_WRITE_ACK_EN
            rsp_write_q <= rsp_write_d;
`endif
        end
    end

endmodule

// File: tb/tb_memory_port_sequencer.sv
// Scoreboard bench for memory_port_sequencer with a behavioural RAM and memory model.
module tb_memory_port_sequencer;

    localparam int DW = 8;
    localparam int DEPTH = 1024;
    localparam int AW = 10;

    logic          clk, reset;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_address;
    logic [DW-1:0] req_data;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0] rsp_data;
    logic          mem_write_en;
    logic [DW-1:0] mem_data_in, mem_data_out;
    logic [AW-1:0] mem_address;

    memory_port_sequencer #(.DATAWIDTH(DW), .DATADEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_write_i   (req_write),
        .req_address_i (req_address),
        .req_data_i    (req_data),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_write_o   (rsp_write),
        .rsp_data_o    (rsp_data),
        .mem_write_en_o(mem_write_en),
        .mem_data_in_o (mem_data_in),
        .mem_address_o (mem_address),
        .mem_data_out_i(mem_data_out)
    );

    // Single-port RAM: write at the edge, read address registered at the edge.
    logic [DW-1:0] ram [DEPTH];
    logic [AW-1:0] ram_addr_q;
    always @(posedge clk) begin
        if (mem_write_en) ram[mem_address] <= mem_data_in;
        ram_addr_q <= mem_address;
    end
    assign mem_data_out = ram[ram_addr_q];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [DW-1:0] data;
        bit            wr;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model_mem [DEPTH];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    bit            rand_rsp = 0;
    bit            ack_en;

`ifdef MEMORY_PORT_SEQUENCER_WRITE_ACK_EN
    initial ack_en = 1'b1;
`else
    initial ack_en = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rand_rsp) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one request; on acceptance update the model and queue the expected response.
    task automatic do_req(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int acc_cyc, output int waits);
        exp_t e;
        bit   done = 0;
        req_valid   = 1'b1;
        req_write   = w;
        req_address = a;
        req_data    = d;
        waits       = 0;
        acc_cyc     = -1;
        while (!done) begin
            @(negedge clk);
            if (req_ready) begin
                done    = 1;
                acc_cyc = cyc;
                check(mem_address == a, "accept_mem_address", 32'(mem_address), 32'(a));
                check(mem_write_en == w, "accept_mem_write_en", 32'(mem_write_en), 32'(w));
                if (w) begin
                    check(mem_data_in == d, "accept_mem_data_in", 32'(mem_data_in), 32'(d));
                    model_mem[a] = d;
                    if (ack_en) begin
                        e.data = d; e.wr = 1; e.cyc = cyc;
                        sb.push_back(e);
                    end
                end else begin
                    e.data = model_mem[a]; e.wr = 0; e.cyc = cyc;
                    sb.push_back(e);
                end
            end else begin
                waits++;
                if (waits > 60) begin
                    check(1'b0, "req_ready_timeout", 32'(waits), 32'd60);
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Monitor: latency, stability under backpressure, and data on every pop.
    bit            prev_valid = 0, popped_last = 0;
    logic [DW-1:0] held_data;
    logic          held_wr;
    always @(negedge clk) begin
        if (reset) begin
            check(!req_ready, "reset_req_ready", 32'(req_ready), 32'd0);
            check(!mem_write_en, "reset_mem_write_en", 32'(mem_write_en), 32'd0);
            check(!rsp_valid, "reset_rsp_valid", 32'(rsp_valid), 32'd0);
            prev_valid  = 0;
            popped_last = 0;
        end else begin
            if (mem_write_en)
                check(req_valid && req_write, "spurious_write", 32'(req_valid), 32'd1);
            if (rsp_valid) begin
                if (!prev_valid || popped_last) begin
                    if (sb.size() == 0)
                        check(1'b0, "unexpected_rsp", 32'(rsp_data), 32'd0);
                    else
                        check(cyc == sb[0].cyc + (sb[0].wr ? 1 : 2), "rsp_latency",
                              32'(cyc - sb[0].cyc), 32'(sb[0].wr ? 1 : 2));
                end else begin
                    check(rsp_data == held_data, "rsp_data_stable", 32'(rsp_data),
                          32'(held_data));
                    check(rsp_write == held_wr, "rsp_write_stable", 32'(rsp_write),
                          32'(held_wr));
                    check(!req_ready || rsp_ready, "req_ready_bp", 32'(req_ready), 32'd0);
                end
                held_data = rsp_data;
                held_wr   = rsp_write;
                if (rsp_ready) begin
                    if (sb.size() > 0) begin
                        check(rsp_data == sb[0].data, "rsp_data", 32'(rsp_data),
                              32'(sb[0].data));
                        check(rsp_write == sb[0].wr, "rsp_write", 32'(rsp_write),
                              32'(sb[0].wr));
                        void'(sb.pop_front());
                    end
                    popped_last = 1;
                end else begin
                    popped_last = 0;
                end
            end else begin
                popped_last = 0;
            end
            prev_valid = rsp_valid;
        end
    end

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check(rsp_valid == 0, {tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check(rsp_data == 0, {tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check(rsp_write == 0, {tag, "_rsp_write"}, 32'(rsp_write), 32'd0);
        check(mem_address == 0, {tag, "_mem_address"}, 32'(mem_address), 32'd0);
        check(mem_data_in == 0, {tag, "_mem_data_in"}, 32'(mem_data_in), 32'd0);
        check(req_ready == 1, {tag, "_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, w, prev_acc;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]       = '0;
            model_mem[i] = '0;
        end
        reset = 1; req_valid = 0; req_write = 0; req_address = '0; req_data = '0;
        rsp_ready = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        check_reset_state("init");

        // Write then immediate read of the same address.
        @(posedge clk); #1;
        do_req(1, 10, 8'hA5, acc, w);
        do_req(0, 10, 8'h00, acc, w);
        repeat (3) @(posedge clk); #1;

        // Back-to-back writes, then readback in order.
        for (int i = 0; i < 16; i++) begin
            do_req(1, AW'(i), DW'(i), acc, w);
            check(w == 0, "b2b_write_ready", 32'(w), 32'd0);
        end
        for (int i = 0; i < 16; i++) do_req(0, AW'(i), 8'h00, acc, w);
        repeat (3) @(posedge clk); #1;

        // Backpressure: response held, new request ignored, then pop+accept together.
        do_req(1, 3, 8'h3C, acc, w);
        rsp_ready = 0;
        do_req(0, 3, 8'h00, acc, w);
        @(posedge clk); #1;
        req_valid = 1; req_write = 0; req_address = 12;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check(rsp_valid == 1, "bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check(rsp_data == 8'h3C, "bp_rsp_data", 32'(rsp_data), 32'h3C);
            check(req_ready == 0, "bp_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1;
        do_req(0, 12, 8'h00, acc, w);
        check(w == 0, "bp_pop_accept_same_cycle", 32'(w), 32'd0);
        repeat (3) @(posedge clk); #1;

        // Streaming reads: one accept every two cycles.
        prev_acc = -1;
        for (int i = 0; i < 8; i++) begin
            do_req(0, AW'(i + 2), 8'h00, acc, w);
            if (prev_acc >= 0)
                check(acc - prev_acc == 2, "stream_read_interval", 32'(acc - prev_acc), 32'd2);
            prev_acc = acc;
        end
        repeat (3) @(posedge clk); #1;

        if (ack_en) begin
            do_req(1, 10'd1023, 8'h77, acc, w);
            do_req(0, 10'd1023, 8'h00, acc, w);
            repeat (3) @(posedge clk); #1;
        end

        // Reset in the middle of a read: nothing may come out afterwards.
        do_req(0, 5, 8'h00, acc, w);
        reset = 1;
        sb.delete();
        repeat (3) @(posedge clk);
        #1 reset = 0;
        check_reset_state("midread");
        repeat (6) @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = ram[i];

        // Randomised traffic over a small address window to provoke read-after-write.
        rand_rsp = 1;
        for (int i = 0; i < 300; i++) begin
            do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
                   acc, w);
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rand_rsp = 0;
        #1 rsp_ready = 1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check(sb.size() == 0, "scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
